// File: rtl/demux3_buf.sv
// -----------------------------------------------------------------------------
// demux3_buf
//   1-to-3 routing distributor with per-destination buffering. A single
//   producer offers a word plus a 2-bit destination select. Each accepted word
//   is pushed into one of three FIFOs, and each FIFO drains through its own
//   valid/ready port. A word with select 2'b11 is accepted and dropped, and it
//   sets a sticky error flag.
//
// Parameters
//   WIDTH  data word width in bits
//   DEPTH  entries per destination FIFO (power of two, >= 2)
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   in_data/in_sel      word and destination (00->1, 01->2, 10->3, 11->illegal)
//   in_valid/in_ready   producer handshake; in_ready is combinational
//   outN_data           head of FIFO N (0 when empty after reset)
//   outN_valid          FIFO N non-empty
//   outN_ready          consumer N takes the head this cycle
//   sel_err             sticky: an illegal-select word was accepted
// -----------------------------------------------------------------------------
module demux3_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out3_data,
  output logic             out3_valid,
  input  logic             out3_ready,
  output logic             sel_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [CW-1:0]    cnt    [3];
  logic [AW-1:0]    wr_ptr [3];
  logic [AW-1:0]    rd_ptr [3];
  logic [WIDTH-1:0] mem    [3][DEPTH];
  logic [WIDTH-1:0] head   [3];

  logic [2:0] push;
  logic [2:0] pop;
  logic [2:0] out_valid;
  logic [2:0] out_ready;

  assign out_ready = {out3_ready, out2_ready, out1_ready};

  // Readiness depends only on the targeted FIFO's occupancy; a pop on the
  // same edge does not open a slot early, so a full FIFO always stalls.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    in_ready = 1'b1;
    case (in_sel)
      2'b00:   in_ready = (cnt[0] < FULL);
      2'b01:   in_ready = (cnt[1] < FULL);
      2'b10:   in_ready = (cnt[2] < FULL);
      default: in_ready = 1'b1;
    endcase
  end

  always_comb begin
    push = '0;
    if (in_valid && in_ready && (in_sel != 2'b11)) begin
      push[in_sel] = 1'b1;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    assign out_valid[g] = (cnt[g] != '0);
    assign pop[g]       = out_valid[g] & out_ready[g];
    assign head[g]      = mem[g][rd_ptr[g]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[g]    <= '0;
        wr_ptr[g] <= '0;
        rd_ptr[g] <= '0;
        // NOTE: the storage array is reset deliberately so outN_data is a
        // defined 0 after reset rather than X; this costs reset fan-out on
        // every storage bit, acceptable at this small depth.
        for (int i = 0; i < DEPTH; i++) begin
          mem[g][i] <= '0;
        end
      end else begin
        if (push[g]) begin
          mem[g][wr_ptr[g]] <= in_data;
          wr_ptr[g]         <= wr_ptr[g] + 1'b1;
        end
        if (pop[g]) begin
          rd_ptr[g] <= rd_ptr[g] + 1'b1;
        end
        // Simultaneous push and pop leaves the count unchanged.
        case ({push[g], pop[g]})
          2'b10:   cnt[g] <= cnt[g] + 1'b1;
          2'b01:   cnt[g] <= cnt[g] - 1'b1;
          default: cnt[g] <= cnt[g];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else if (in_valid && in_ready && (in_sel == 2'b11)) begin
      sel_err <= 1'b1;
    end
  end

  assign out1_data  = head[0];
  assign out2_data  = head[1];
  assign out3_data  = head[2];
  assign out1_valid = out_valid[0];
  assign out2_valid = out_valid[1];
  assign out3_valid = out_valid[2];

endmodule

// File: tb/tb_demux3_buf.sv
// -----------------------------------------------------------------------------
// tb_demux3_buf
//   Directed self-checking bench for demux3_buf (WIDTH=16, DEPTH=2). Inputs
//   change 1 time unit after a rising edge; outputs are checked at that point,
//   well away from the next active edge.
// -----------------------------------------------------------------------------
module tb_demux3_buf;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out1_data, out2_data, out3_data;
  logic             out1_valid, out2_valid, out3_valid;
  logic             out1_ready, out2_ready, out3_ready;
  logic             sel_err;

  int errors = 0;
  int checks = 0;

  demux3_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out2_data  (out2_data),
    .out2_valid (out2_valid),
    .out2_ready (out2_ready),
    .out3_data  (out3_data),
    .out3_valid (out3_valid),
    .out3_ready (out3_ready),
    .sel_err    (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ports(input logic v1, input logic v2, input logic v3, input string tag);
    check({tag, " out1_valid"}, 32'(out1_valid), 32'(v1));
    check({tag, " out2_valid"}, 32'(out2_valid), 32'(v2));
    check({tag, " out3_valid"}, 32'(out3_valid), 32'(v3));
  endtask

  initial begin
    int sent;
    int rcvd;
    int cyc;
    logic acc_in;
    logic acc_out;
    logic [WIDTH-1:0] seen;

    rst_n      = 1'b0;
    in_data    = '0;
    in_sel     = 2'b00;
    in_valid   = 1'b0;
    out1_ready = 1'b0;
    out2_ready = 1'b0;
    out3_ready = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();

    // Post-reset state.
    idle_ports(1'b0, 1'b0, 1'b0, "post_reset");
    check("post_reset out1_data", 32'(out1_data), 32'h0);
    check("post_reset sel_err", 32'(sel_err), 32'h0);
    check("post_reset in_ready", 32'(in_ready), 32'h1);

    // Routing and one-cycle latency.
    in_valid = 1'b1; in_sel = 2'b00; in_data = 16'hA001;
    #1 check("route1 in_ready", 32'(in_ready), 32'h1);
    tick();
    idle_ports(1'b1, 1'b0, 1'b0, "route1");
    check("route1 out1_data", 32'(out1_data), 32'hA001);
    in_sel = 2'b01; in_data = 16'hB002;
    tick();
    idle_ports(1'b1, 1'b1, 1'b0, "route2");
    check("route2 out2_data", 32'(out2_data), 32'hB002);
    in_sel = 2'b10; in_data = 16'hC003;
    tick();
    idle_ports(1'b1, 1'b1, 1'b1, "route3");
    check("route3 out3_data", 32'(out3_data), 32'hC003);
    check("route3 out1_data held", 32'(out1_data), 32'hA001);

    // Simultaneous push/pop on FIFO 3 holding one entry.
    in_data = 16'h5555; out3_ready = 1'b1;
    tick();
    check("pushpop out3_valid", 32'(out3_valid), 32'h1);
    check("pushpop out3_data", 32'(out3_data), 32'h5555);
    in_valid = 1'b0;
    tick();
    check("pushpop count1 drained", 32'(out3_valid), 32'h0);
    out3_ready = 1'b0;

    // Fill and stall on FIFO 2: drain B002 first.
    out2_ready = 1'b1;
    tick();
    check("fill pre-drain out2_valid", 32'(out2_valid), 32'h0);
    out2_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'b01; in_data = 16'h0011;
    tick();
    in_data = 16'h0022;
    tick();
    in_data = 16'h0033;
    #1 check("fill full in_ready", 32'(in_ready), 32'h0);
    in_sel = 2'b00;
    #1 check("fill other sel in_ready", 32'(in_ready), 32'h1);
    in_sel = 2'b01;
    out2_ready = 1'b1;
    #1 check("fill no bypass in_ready", 32'(in_ready), 32'h0);
    tick();
    out2_ready = 1'b0;
    check("fill pop head", 32'(out2_data), 32'h0022);
    check("fill slot freed in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("fill third accepted head", 32'(out2_data), 32'h0022);
    out2_ready = 1'b1;
    tick();
    check("fill drain 0033", 32'(out2_data), 32'h0033);
    check("fill drain valid", 32'(out2_valid), 32'h1);
    tick();
    check("fill drained", 32'(out2_valid), 32'h0);
    out2_ready = 1'b0;

    // Illegal select: FIFO 1 still holds A001.
    in_valid = 1'b1; in_sel = 2'b11; in_data = 16'hDEAD;
    #1 check("illegal in_ready", 32'(in_ready), 32'h1);
    tick();
    in_valid = 1'b0;
    check("illegal sel_err", 32'(sel_err), 32'h1);
    idle_ports(1'b1, 1'b0, 1'b0, "illegal");
    check("illegal out1_data", 32'(out1_data), 32'hA001);

    // Drain A001, then stream 10 words through FIFO 1 with random ready.
    out1_ready = 1'b1;
    tick();
    check("wrap pre-drain", 32'(out1_valid), 32'h0);
    sent = 0;
    rcvd = 0;
    cyc  = 0;
    while ((rcvd < 10) && (cyc < 200)) begin
      in_valid   = (sent < 10);
      in_sel     = 2'b00;
      in_data    = 16'h0100 + 16'(sent);
      out1_ready = 1'($urandom_range(0, 1));
      #1;
      acc_in  = in_valid && in_ready;
      acc_out = out1_valid && out1_ready;
      seen    = out1_data;
      if (acc_out) begin
        check("wrap order", 32'(seen), 32'h0100 + 32'(rcvd));
        rcvd++;
      end
      if (acc_in) sent++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; out1_ready = 1'b0;
    check("wrap received", 32'(rcvd), 32'd10);
    check("wrap sent", 32'(sent), 32'd10);
    check("wrap empty after", 32'(out1_valid), 32'h0);
    check("sel_err sticky", 32'(sel_err), 32'h1);

    // Fill all FIFOs, then reset asynchronously mid-cycle.
    in_valid = 1'b1;
    in_sel = 2'b00; in_data = 16'h1111; tick();
    in_sel = 2'b01; in_data = 16'h2222; tick();
    in_sel = 2'b10; in_data = 16'h3333; tick();
    in_valid = 1'b0;
    idle_ports(1'b1, 1'b1, 1'b1, "prereset");
    #2 rst_n = 1'b0;
    #1;
    idle_ports(1'b0, 1'b0, 1'b0, "async_reset");
    check("async_reset out1_data", 32'(out1_data), 32'h0);
    check("async_reset out2_data", 32'(out2_data), 32'h0);
    check("async_reset out3_data", 32'(out3_data), 32'h0);
    check("async_reset sel_err", 32'(sel_err), 32'h0);
    in_sel = 2'b00; #1 check("async_reset in_ready sel0", 32'(in_ready), 32'h1);
    in_sel = 2'b01; #1 check("async_reset in_ready sel1", 32'(in_ready), 32'h1);
    in_sel = 2'b10; #1 check("async_reset in_ready sel2", 32'(in_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    idle_ports(1'b0, 1'b0, 1'b0, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
